// File: rtl/saes64_encrypt.sv
// Iterative 64-bit simplified-AES encryption core.
// Two AES-style rounds over a 4x4 nibble state. One round is applied per
// clock, and a single round datapath is shared by both rounds. A block is
// accepted when start is seen in IDLE. The ciphertext is ready two edges
// later and is marked by a one-cycle valid pulse.
module saes64_encrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] plaintext,
  input  logic [63:0] secretKey,
  output logic [63:0] ciphertext,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    R1   = 2'd1,
    R2   = 2'd2
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic        accept;
  logic        finish;
  logic [63:0] state_q;
  logic [63:0] key_q;
  logic [63:0] key_rot4;
  logic [63:0] key_rot8;
  logic [63:0] round_key;
  logic [63:0] round_out;

  // Nibble substitution table.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h0;  4'h1: y = 4'h3;  4'h2: y = 4'h8;  4'h3: y = 4'h5;
      4'h4: y = 4'hC;  4'h5: y = 4'hA;  4'h6: y = 4'h1;  4'h7: y = 4'h6;
      4'h8: y = 4'hE;  4'h9: y = 4'h2;  4'hA: y = 4'h9;  4'hB: y = 4'h4;
      4'hC: y = 4'hB;  4'hD: y = 4'h7;  4'hE: y = 4'hD;  default: y = 4'hF;
    endcase
    return y;
  endfunction

  // Multiply by x in GF(2^4) mod x^4+x+1 (x^4 folds back to x+1).
  function automatic logic [3:0] xtime(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  // One round without the key add: SubNibbles, then ShiftRows, then MixColumns.
  // Nibble i sits at bits [63-4i -: 4], column c = i/4, row r = i%4.
  function automatic logic [63:0] round_fn(input logic [63:0] s);
    logic [3:0]  sb [16];
    logic [3:0]  sr [16];
    logic [3:0]  a0, a1, a2, a3;
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(s[63-4*i -: 4]);
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    // out_r = 2*s_r ^ 3*s_(r+1) ^ s_(r+2) ^ s_(r+3)
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a0 = sr[4*c+r];
        a1 = sr[4*c+(r+1)%4];
        a2 = sr[4*c+(r+2)%4];
        a3 = sr[4*c+(r+3)%4];
        o[63-4*(4*c+r) -: 4] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      end
    end
    return o;
  endfunction

  assign key_rot4  = {key_q[59:0], key_q[63:60]};
  assign key_rot8  = {key_q[55:0], key_q[63:56]};
  assign round_key = (fsm_q == R1) ? key_q : key_rot4;
  assign round_out = round_fn(state_q ^ round_key);

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state and control decode; start is only honoured in IDLE.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would infer a latch.
  always_comb begin
    fsm_d  = fsm_q;
    accept = 1'b0;
    finish = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          fsm_d  = R1;
        end
      end
      R1: fsm_d = R2;
      R2: begin
        finish = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath: capture inputs, apply the rounds, publish the result.
  // NOTE: the round state and key registers are reset as well, so an aborted
  // block leaves no key material behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= '0;
      key_q      <= '0;
      ciphertext <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= finish;
      if (accept) begin
        state_q <= plaintext;
        key_q   <= secretKey;
        busy    <= 1'b1;
      end
      if (fsm_q == R1) begin
        state_q <= round_out;
      end
      if (finish) begin
        ciphertext <= round_out ^ key_rot8;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saes64_encrypt.sv
// Self-checking bench for saes64_encrypt.
// The reference model works on a 4x4 matrix of nibbles and uses a generic
// GF(2^4) multiply.
module tb_saes64_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] plaintext;
  logic [63:0] secretKey;
  logic [63:0] ciphertext;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] sbox_tbl [16] = '{4'h0, 4'h3, 4'h8, 4'h5, 4'hC, 4'hA, 4'h1, 4'h6,
                                4'hE, 4'h2, 4'h9, 4'h4, 4'hB, 4'h7, 4'hD, 4'hF};

  saes64_encrypt dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .secretKey  (secretKey),
    .ciphertext (ciphertext),
    .valid      (valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-add multiply in GF(2^4) with reduction by x^4+x+1 (0x13).
  function automatic int gmul(input int a, input int b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 4; i++) begin
      if ((b >> i) & 1) p ^= x;
      x = x << 1;
      if (x & 16) x ^= 'h13;
    end
    return p & 15;
  endfunction

  // Reference encryption. m[row][col] holds nibble 4*col+row.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [63:0] key);
    logic [63:0] rk [3];
    logic [63:0] s;
    int          m [4][4];
    int          t [4][4];
    rk[0] = key;
    rk[1] = (key << 4) | (key >> 60);
    rk[2] = (key << 8) | (key >> 56);
    s = pt;
    for (int rnd = 0; rnd < 2; rnd++) begin
      s = s ^ rk[rnd];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          m[r][c] = int'(sbox_tbl[s[63-4*(4*c+r) -: 4]]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = m[r][(c+r)%4];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          m[r][c] = gmul(2, t[r][c]) ^ gmul(3, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[63-4*(4*c+r) -: 4] = 4'(m[r][c]);
    end
    return s ^ rk[2];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One block with handshake checks. Inputs are scrambled after acceptance.
  task automatic run_block(input logic [63:0] pt, input logic [63:0] key,
                           input logic [63:0] exp, input string tag);
    @(negedge clk);
    start = 1'b1; plaintext = pt; secretKey = key;
    @(posedge clk); #1;
    check({tag, " busy@E0"},  64'(busy),  64'd1);
    check({tag, " valid@E0"}, 64'(valid), 64'd0);
    @(negedge clk);
    start = 1'b0; plaintext = rand64(); secretKey = rand64();
    @(posedge clk); #1;
    check({tag, " busy@E1"},  64'(busy),  64'd1);
    check({tag, " valid@E1"}, 64'(valid), 64'd0);
    @(posedge clk); #1;
    check({tag, " busy@E2"},  64'(busy),  64'd0);
    check({tag, " valid@E2"}, 64'(valid), 64'd1);
    check({tag, " ct"},       ciphertext, exp);
  endtask

  initial begin
    logic [63:0] pt, key, exp;
    logic [63:0] expq [$];

    rst = 1'b1; start = 1'b0; plaintext = '0; secretKey = '0;
    #1;
    check("reset ct",    ciphertext, 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset busy",  64'(busy),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Directed vectors.
    run_block(64'h0, 64'h0, 64'h0, "zero");
    run_block(64'h1111111111111111, 64'h2222222222222222, 64'h4444444444444444, "uniform12");
    run_block(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, "allF");

    // Random back-to-back blocks against the model.
    for (int n = 0; n < 1000; n++) begin
      pt = rand64(); key = rand64();
      run_block(pt, key, ref_encrypt(pt, key), "rand");
    end
    @(posedge clk); #1;
    check("valid drops", 64'(valid), 64'd0);

    // start held high for 10 cycles while inputs change every cycle.
    // Blocks must be accepted at edges 0, 3, 6, 9 only.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = (k < 10);
      plaintext = rand64(); secretKey = rand64();
      @(posedge clk);
      if (start && (k % 3 == 0)) expq.push_back(ref_encrypt(plaintext, secretKey));
      #1;
      check($sformatf("held busy k=%0d", k),  64'(busy),  64'((k % 3) != 2));
      check($sformatf("held valid k=%0d", k), 64'(valid), 64'((k % 3) == 2));
      if (k % 3 == 2) begin
        if (expq.size() == 0) check("held queue empty", 64'd1, 64'd0);
        else                  check($sformatf("held ct k=%0d", k), ciphertext, expq.pop_front());
      end
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("held idle busy", 64'(busy), 64'd0);

    // Asynchronous reset during R2.
    pt = rand64(); key = rand64();
    @(negedge clk);
    start = 1'b1; plaintext = pt; secretKey = key;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort ct",    ciphertext, 64'd0);
    check("abort valid", 64'(valid), 64'd0);
    check("abort busy",  64'(busy),  64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("abort no valid", 64'(valid), 64'd0);
    end
    @(negedge clk); rst = 1'b0;
    pt = rand64(); key = rand64();
    exp = ref_encrypt(pt, key);
    run_block(pt, key, exp, "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
